sng_pair: RTL and testbench

- Dual-channel stochastic number generator (SNG) that converts two N-bit binary probabilities into a pair of unipolar bitstreams x, y.
- Sits directly upstream of the sequential recorrelator and drives its x/y inputs.
- Input correlation is fixed at elaboration: correlated (SCC=+1), uncorrelated, or anticorrelated (SCC=-1). This lets the recorrelator be exercised and characterised against known starting correlations.

---
 rtl/sng_pair.sv | 152 +++++++++++++++
 tb/tb_sng_pair.sv | 259 +++++++++++++++++++++++++
 2 files changed

// File: rtl/sng_pair.sv
// sng_pair: dual-channel stochastic number generator turning px/py into unipolar bitstreams x/y.
// Latency: bit 0 is valid one cycle after start is sampled; LEN consecutive valid bits, done on the last.
// Backpressure: none; start is ignored while busy and every valid bit must be consumed when presented.
//
// Ports: clk, rst_n   rising-edge clock, asynchronous active-low reset
//        start        request one stream (sampled only while idle)
//        px, py       probability numerators, P = p/(2^N-1), latched at start
//        x, y, valid  registered stream bits and their qualifier
//        busy         high while a stream is being generated
//        done         one-cycle pulse on the last valid bit
module sng_pair #(
    parameter int          N      = 8,
    parameter int          LEN    = 255,
    parameter int          MODE   = 0,
    parameter int unsigned SEED_A = 1,
    parameter int unsigned SEED_B = 'hA5
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         start,
    input  logic [N-1:0] px,
    input  logic [N-1:0] py,
    output logic         x,
    output logic         y,
    output logic         valid,
    output logic         busy,
    output logic         done
);

    localparam int CW = $clog2(LEN + 1);

    // Primitive feedback polynomials, one per width; bit k set means stage k+1 feeds back.
    function automatic logic [15:0] tap_mask(input int n);
        case (n)
            4:       return 16'h000C;
            5:       return 16'h0014;
            6:       return 16'h0030;
            7:       return 16'h0060;
            8:       return 16'h00B8;
            9:       return 16'h0110;
            10:      return 16'h0240;
            11:      return 16'h0500;
            12:      return 16'h0829;
            13:      return 16'h100D;
            14:      return 16'h2015;
            15:      return 16'h6000;
            16:      return 16'hD008;
            default: return 16'h0000;
        endcase
    endfunction

    localparam logic [N-1:0] TAPS       = N'(tap_mask(N));
    localparam logic [N-1:0] SEED_A_RAW = N'(SEED_A);
    // An all-zero seed would lock the LFSR, so it is forced to 1.
    localparam logic [N-1:0] SEED_A_EFF = (SEED_A_RAW == '0) ? N'(1) : SEED_A_RAW;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    state_t         state_q, state_d;
    logic           load, step, last;
    logic [N-1:0]   px_q, py_q;
    logic [N-1:0]   lfsr_a_q, lfsr_a_nxt;
    logic [CW-1:0]  cnt_q;
    logic           x_bit, y_bit;

    assign last       = (cnt_q == CW'(LEN - 1));
    assign lfsr_a_nxt = {lfsr_a_q[N-2:0], ^(lfsr_a_q & TAPS)};
    assign x_bit      = (lfsr_a_q <= px_q);
    assign busy       = (state_q == RUN);

    always_comb begin
        state_d = state_q;
        load    = 1'b0;
        step    = 1'b0;
        case (state_q)
            IDLE: begin
                if (start) begin
                    load    = 1'b1;
                    state_d = RUN;
                end
            end
            RUN: begin
                step = 1'b1;
                if (last) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // y comparison source depends on the elaborated correlation mode.
    generate
        if (MODE == 1) begin : g_indep
            localparam logic [N-1:0] SEED_B_RAW = N'(SEED_B);
            localparam logic [N-1:0] SEED_B_EFF = (SEED_B_RAW == '0) ? N'(1) : SEED_B_RAW;
            logic [N-1:0] lfsr_b_q;

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    lfsr_b_q <= SEED_B_EFF;
                end else if (load) begin
                    lfsr_b_q <= SEED_B_EFF;
                end else if (step) begin
                    lfsr_b_q <= {lfsr_b_q[N-2:0], ^(lfsr_b_q & TAPS)};
                end
            end

            assign y_bit = (lfsr_b_q <= py_q);
        end else if (MODE == 2) begin : g_anti
            // 2^N - r maps 1..2^N-1 onto 2^N-1..1, so an extra bit keeps it exact.
            logic [N:0] r_comp;
            assign r_comp = {1'b1, {N{1'b0}}} - {1'b0, lfsr_a_q};
            assign y_bit  = (r_comp <= {1'b0, py_q});
        end else begin : g_shared
            assign y_bit = (lfsr_a_q <= py_q);
        end
    endgenerate

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            px_q     <= '0;
            py_q     <= '0;
            lfsr_a_q <= SEED_A_EFF;
            cnt_q    <= '0;
            x        <= 1'b0;
            y        <= 1'b0;
            valid    <= 1'b0;
            done     <= 1'b0;
        end else begin
            state_q <= state_d;
            valid   <= step;
            done    <= step & last;
            x       <= step & x_bit;
            y       <= step & y_bit;
            if (load) begin
                px_q     <= px;
                py_q     <= py;
                lfsr_a_q <= SEED_A_EFF;
                cnt_q    <= '0;
            end else if (step) begin
                lfsr_a_q <= lfsr_a_nxt;
                cnt_q    <= cnt_q + CW'(1);
            end
        end
    end

endmodule

// File: tb/tb_sng_pair.sv
module tb_sng_pair;

    localparam int LEN  = 255;
    localparam int FULL = 255;

    logic       clk   = 1'b0;
    logic       rst_n = 1'b0;
    logic       start = 1'b0;
    logic [7:0] px    = '0;
    logic [7:0] py    = '0;
    logic [2:0] x, y, valid, busy, done;

    always #5 clk = ~clk;

    sng_pair #(.N(8), .LEN(LEN), .MODE(0), .SEED_A(1), .SEED_B('hA5)) u_m0 (
        .clk(clk), .rst_n(rst_n), .start(start), .px(px), .py(py),
        .x(x[0]), .y(y[0]), .valid(valid[0]), .busy(busy[0]), .done(done[0]));
    sng_pair #(.N(8), .LEN(LEN), .MODE(1), .SEED_A(1), .SEED_B('hA5)) u_m1 (
        .clk(clk), .rst_n(rst_n), .start(start), .px(px), .py(py),
        .x(x[1]), .y(y[1]), .valid(valid[1]), .busy(busy[1]), .done(done[1]));
    sng_pair #(.N(8), .LEN(LEN), .MODE(2), .SEED_A(1), .SEED_B('hA5)) u_m2 (
        .clk(clk), .rst_n(rst_n), .start(start), .px(px), .py(py),
        .x(x[2]), .y(y[2]), .valid(valid[2]), .busy(busy[2]), .done(done[2]));

    int errors = 0;
    int checks = 0;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Reference random sequences: maximal-length x^8+x^6+x^5+x^4+1 sequence from each seed.
    logic [7:0] seq_a [LEN];
    logic [7:0] seq_b [LEN];

    function automatic logic [7:0] lfsr_step(input logic [7:0] v);
        return {v[6:0], ^(v & 8'hB8)};
    endfunction

    // Expected entry: {px, py, done, y, x}
    typedef logic [18:0] ent_t;
    ent_t q0[$], q1[$], q2[$];

    int   rem       = 0;
    logic exp_valid = 1'b0;
    int   cx[3], cy[3], cxy[3], cxny[3], cnxy[3], idx[3], n_done[3];
    logic [LEN-1:0] yseq[3], last_y[3];

    task automatic clear_acc(input int m);
        cx[m] = 0; cy[m] = 0; cxy[m] = 0; cxny[m] = 0; cnxy[m] = 0; idx[m] = 0;
        yseq[m] = '0;
    endtask

    task automatic push_stream(input logic [7:0] a, input logic [7:0] b);
        for (int i = 0; i < LEN; i++) begin
            logic xb, y0b, y1b, y2b, d;
            xb  = (seq_a[i] <= a);
            y0b = (seq_a[i] <= b);
            y1b = (seq_b[i] <= b);
            y2b = ((256 - int'(seq_a[i])) <= int'(b));
            d   = (i == LEN - 1);
            q0.push_back({a, b, d, y0b, xb});
            q1.push_back({a, b, d, y1b, xb});
            q2.push_back({a, b, d, y2b, xb});
        end
    endtask

    function automatic int qsize(input int m);
        case (m)
            0:       return q0.size();
            1:       return q1.size();
            default: return q2.size();
        endcase
    endfunction

    function automatic ent_t qpop(input int m);
        case (m)
            0:       return q0.pop_front();
            1:       return q1.pop_front();
            default: return q2.pop_front();
        endcase
    endfunction

    // Stream-level model: a start seen while idle yields LEN bits on the following edges.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rem       = 0;
            exp_valid = 1'b0;
            q0.delete(); q1.delete(); q2.delete();
            for (int m = 0; m < 3; m++) clear_acc(m);
        end else begin
            exp_valid = (rem > 0);
            if (rem > 0) begin
                rem = rem - 1;
            end else if (start) begin
                push_stream(px, py);
                rem = LEN;
            end
        end
    end

    task automatic mon(input int m, input logic xv, input logic yv, input logic vv,
                       input logic bv, input logic dv);
        ent_t e;
        int   ea, eb;
        chk($sformatf("m%0d_valid", m), vv, exp_valid);
        chk($sformatf("m%0d_busy", m), bv, int'(rem > 0));
        if (dv) n_done[m]++;
        if (vv && exp_valid) begin
            chk($sformatf("m%0d_exp_avail", m), int'(qsize(m) > 0), 1);
            if (qsize(m) > 0) begin
                e  = qpop(m);
                ea = int'(e[18:11]);
                eb = int'(e[10:3]);
                chk($sformatf("m%0d_x_bit%0d", m, idx[m]), xv, e[0]);
                chk($sformatf("m%0d_y_bit%0d", m, idx[m]), yv, e[1]);
                chk($sformatf("m%0d_done_bit%0d", m, idx[m]), dv, e[2]);
                cx[m]   += int'(xv);
                cy[m]   += int'(yv);
                cxy[m]  += int'(xv & yv);
                cxny[m] += int'(xv & ~yv);
                cnxy[m] += int'(~xv & yv);
                if (idx[m] < LEN) yseq[m][idx[m]] = yv;
                idx[m]++;
                if (e[2]) begin
                    chk($sformatf("m%0d_count_x px=%0d", m, ea), cx[m], ea);
                    chk($sformatf("m%0d_count_y py=%0d", m, eb), cy[m], eb);
                    if (m == 0 && ea <= eb) chk("m0_x_and_not_y", cxny[m], 0);
                    if (m == 0 && eb <= ea) chk("m0_y_and_not_x", cnxy[m], 0);
                    if (m == 2) chk("m2_count_xy", cxy[m], (ea + eb > FULL) ? ea + eb - FULL : 0);
                    last_y[m] = yseq[m];
                    clear_acc(m);
                end
            end
        end else if (!vv) begin
            chk($sformatf("m%0d_done_idle", m), dv, 0);
        end
    endtask

    always @(negedge clk) begin
        if (rst_n) begin
            for (int m = 0; m < 3; m++) mon(m, x[m], y[m], valid[m], busy[m], done[m]);
        end
    end

    task automatic wait_idle();
        int n;
        n = 0;
        while ((rem > 0 || q0.size() > 0) && n < 1000) begin
            @(negedge clk);
            n++;
        end
        chk("stream_completes_in_budget", int'(n < 1000), 1);
    endtask

    task automatic run_stream(input logic [7:0] a, input logic [7:0] b);
        @(negedge clk);
        px    = a;
        py    = b;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        wait_idle();
    endtask

    task automatic check_all_zero(input string tag);
        for (int m = 0; m < 3; m++) begin
            chk($sformatf("%s_m%0d_x", tag, m), x[m], 0);
            chk($sformatf("%s_m%0d_y", tag, m), y[m], 0);
            chk($sformatf("%s_m%0d_valid", tag, m), valid[m], 0);
            chk($sformatf("%s_m%0d_busy", tag, m), busy[m], 0);
            chk($sformatf("%s_m%0d_done", tag, m), done[m], 0);
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1);
    end

    initial begin
        int d0;
        seq_a[0] = 8'h01;
        seq_b[0] = 8'hA5;
        for (int i = 1; i < LEN; i++) begin
            seq_a[i] = lfsr_step(seq_a[i-1]);
            seq_b[i] = lfsr_step(seq_b[i-1]);
        end
        for (int m = 0; m < 3; m++) begin
            clear_acc(m);
            n_done[m] = 0;
            last_y[m] = '0;
        end

        #12;
        check_all_zero("reset");
        @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        run_stream(8'd0, 8'd255);
        run_stream(8'd128, 8'd64);
        run_stream(8'd128, 8'd128);
        run_stream(8'd100, 8'd200);
        chk("m1_y_differs_from_m0", int'(last_y[0] != last_y[1]), 1);

        // start held high across two streams, px disturbed mid-stream and restored
        d0 = n_done[0];
        @(negedge clk);
        px    = 8'd50;
        py    = 8'd200;
        start = 1'b1;
        for (int i = 1; i <= 300; i++) begin
            @(negedge clk);
            if (i == 100) px = px ^ 8'h5A;
            if (i == 240) px = 8'd50;
        end
        start = 1'b0;
        wait_idle();
        chk("held_start_stream_count", n_done[0] - d0, 2);

        // reset while bit 50 is being registered
        @(negedge clk);
        px    = 8'd77;
        py    = 8'd150;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (50) @(negedge clk);
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check_all_zero("midreset");
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        run_stream(8'd77, 8'd150);

        for (int k = 0; k < 6; k++) begin
            logic [7:0] a, b;
            a = 8'($urandom_range(0, 255));
            b = 8'($urandom_range(0, 255));
            if (k == 0) a = 8'd255;
            if (k == 1) b = 8'd0;
            repeat ($urandom_range(0, 3)) @(negedge clk);
            run_stream(a, b);
        end

        repeat (3) @(negedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
